// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with ripple borrow, load clamping and active-low
// seven-segment decode; pulses done for one cycle when the count reaches zero.

module bcd_countdown_digit (
   input  logic [3:0] value,
   input  logic [3:0] raw,
   input  logic       borrow_in,
   output logic [3:0] dec,
   output logic [3:0] clamp,
   output logic [6:0] seg
);
   always_comb begin
      dec = value;
      if (borrow_in) dec = (value == 4'd0) ? 4'd9 : value - 4'd1;
   end

   assign clamp = (raw > 4'd9) ? 4'd9 : raw;

   always_comb begin
      case (value)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

module bcd_countdown #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   count,
   output logic [7*DIGITS-1:0]   HEX,
   output logic                  running,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t              state, state_n;
   logic [4*DIGITS-1:0] count_n, dec, clamp;
   logic [DIGITS-1:0]   borrow;
   logic                done_n;

   // Digit 0 always borrows; higher digits borrow only through a chain of zeros.
   assign borrow[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bcd_countdown_digit u_dig (
         .value     (count[4*i +: 4]),
         .raw       (load_value[4*i +: 4]),
         .borrow_in (borrow[i]),
         .dec       (dec[4*i +: 4]),
         .clamp     (clamp[4*i +: 4]),
         .seg       (HEX[7*i +: 7])
      );
      if (i < DIGITS-1) begin : g_brw
         assign borrow[i+1] = borrow[i] & (count[4*i +: 4] == 4'd0);
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      done_n  = 1'b0;
      if (load) begin
         count_n = clamp;
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (!pause && start && count != '0) state_n = RUN;
            RUN: begin
               if (pause) state_n = PAUSED;
               else if (tick) begin
                  count_n = dec;
                  if (dec == '0) begin
                     state_n = EXPIRED;
                     done_n  = 1'b1;
                  end
               end
            end
            PAUSED:  if (!pause && start) state_n = RUN;
            default: state_n = EXPIRED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         done    <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_n;
         count   <= count_n;
         done    <= done_n;
         running <= (state_n == RUN);
      end
   end
endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: vector table with expectation scoreboard on a 2-digit
// instance, plus hand sequences for reset and 3-digit multi-borrow.

module tb_bcd_countdown;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, load, start, pause, tick;
   logic [7:0]  load_value, count;
   logic [13:0] HEX;
   logic        running, done;

   logic        load3, start3, pause3, tick3;
   logic [11:0] lv3, count3;
   logic [20:0] hex3;
   logic        run3, done3;

   int n_tests = 0;
   int n_fail  = 0;

   bcd_countdown #(.DIGITS(2)) dut (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .start(start), .pause(pause), .tick(tick),
      .count(count), .HEX(HEX), .running(running), .done(done)
   );

   bcd_countdown #(.DIGITS(3)) dut3 (
      .clk(clk), .reset(reset), .load(load3), .load_value(lv3),
      .start(start3), .pause(pause3), .tick(tick3),
      .count(count3), .HEX(hex3), .running(run3), .done(done3)
   );

   typedef struct {
      logic       rst, ld;
      logic [7:0] lv;
      logic       st, ps, tk;
      logic [7:0] ecnt;
      logic       edone, erun;
   } vec_t;

   typedef struct {
      logic [7:0] cnt;
      logic       dn, rn;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic void add(input logic rst, input logic ld, input logic [7:0] lv,
                               input logic st, input logic ps, input logic tk,
                               input logic [7:0] ecnt, input logic edone, input logic erun);
      vec_t v;
      v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.tk = tk;
      v.ecnt = ecnt; v.edone = edone; v.erun = erun;
      vecs.push_back(v);
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] bcd8(input int k);
      logic [7:0] r;
      r[7:4] = 4'(k / 10);
      r[3:0] = 4'(k % 10);
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; load_value = 8'h00;
      load3 = 1'b0; start3 = 1'b0; pause3 = 1'b0; tick3 = 1'b0; lv3 = 12'h000;

      // Reset with random inputs on both instances
      repeat (2) begin
         load = 1'($urandom); start = 1'($urandom); pause = 1'($urandom);
         tick = 1'($urandom); load_value = 8'($urandom);
         load3 = 1'($urandom); start3 = 1'($urandom); tick3 = 1'($urandom);
         lv3 = 12'($urandom);
         @(posedge clk);
      end
      #1;
      check("rst count", 32'(count), 32'h00);
      check("rst done", 32'(done), 32'h0);
      check("rst running", 32'(running), 32'h0);
      check("rst HEX", 32'(HEX), 32'(14'b1000000_1000000));
      check("rst count3", 32'(count3), 32'h000);
      check("rst HEX3", 32'(hex3), 32'(21'b1000000_1000000_1000000));
      load3 = 1'b0; start3 = 1'b0; pause3 = 1'b0; tick3 = 1'b0;

      // Full count from 12 with ticks spaced 3 cycles
      add(0, 1, 8'h12, 0, 0, 0, 8'h12, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0, 8'h12, 0, 1);
      for (int k = 11; k >= 0; k--) begin
         add(0, 0, 8'h00, 0, 0, 1, bcd8(k), k == 0, k != 0);
         add(0, 0, 8'h00, 0, 0, 0, bcd8(k), 0, k != 0);
         add(0, 0, 8'h00, 0, 0, 0, bcd8(k), 0, k != 0);
      end
      add(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      add(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0);
      // Pause
      add(0, 1, 8'h05, 0, 0, 0, 8'h05, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0, 8'h05, 0, 1);
      add(0, 0, 8'h00, 0, 0, 1, 8'h04, 0, 1);
      add(0, 0, 8'h00, 0, 0, 1, 8'h03, 0, 1);
      add(0, 0, 8'h00, 0, 1, 1, 8'h03, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 8'h03, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 8'h03, 0, 0);
      add(0, 0, 8'h00, 1, 1, 1, 8'h03, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0, 8'h03, 0, 1);
      add(0, 0, 8'h00, 0, 0, 1, 8'h02, 0, 1);
      // Edge loads
      add(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      add(0, 1, 8'hA3, 0, 0, 0, 8'h93, 0, 0);
      add(0, 1, 8'h7F, 0, 0, 0, 8'h79, 0, 0);
      add(0, 1, 8'hA3, 0, 0, 0, 8'h93, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0, 8'h93, 0, 1);
      add(0, 0, 8'h00, 0, 0, 1, 8'h92, 0, 1);
      add(0, 1, 8'h40, 0, 0, 1, 8'h40, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 8'h40, 0, 0);
      // Reset mid-run
      add(0, 1, 8'h50, 0, 0, 0, 8'h50, 0, 0);
      add(0, 0, 8'h00, 1, 0, 0, 8'h50, 0, 1);
      for (int k = 49; k >= 45; k--) add(0, 0, 8'h00, 0, 0, 1, bcd8(k), 0, 1);
      add(1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
      add(0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; load = vecs[i].ld; load_value = vecs[i].lv;
         start = vecs[i].st; pause = vecs[i].ps; tick = vecs[i].tk;
         e.cnt = vecs[i].ecnt; e.dn = vecs[i].edone; e.rn = vecs[i].erun;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("v%0d count", i), 32'(count), 32'(e.cnt));
         check($sformatf("v%0d done", i), 32'(done), 32'(e.dn));
         check($sformatf("v%0d running", i), 32'(running), 32'(e.rn));
         check($sformatf("v%0d HEX", i), 32'(HEX), 32'({seg7(e.cnt[7:4]), seg7(e.cnt[3:0])}));
      end
      reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;

      // Three-digit multi-borrow 100 -> 099 -> 098
      lv3 = 12'h100; load3 = 1'b1;
      @(posedge clk); #1;
      load3 = 1'b0;
      check("d3 load", 32'(count3), 32'h100);
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      check("d3 running", 32'(run3), 32'h1);
      tick3 = 1'b1;
      @(posedge clk); #1;
      tick3 = 1'b0;
      check("d3 borrow count", 32'(count3), 32'h099);
      check("d3 borrow HEX", 32'(hex3), 32'(21'b1000000_0010000_0010000));
      check("d3 borrow done", 32'(done3), 32'h0);
      check("d3 borrow running", 32'(run3), 32'h1);
      tick3 = 1'b1;
      @(posedge clk); #1;
      tick3 = 1'b0;
      check("d3 next count", 32'(count3), 32'h098);
      check("d3 next HEX", 32'(hex3),
            32'({seg7(4'd0), seg7(4'd9), seg7(4'd8)}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
